// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: memory-stage access initiator for the sequential Y86 core.
// Decodes the command, range-checks the 8-byte window, then moves the 64-bit
// word little-endian over a byte-wide req/ack port and returns valM.
//
// state    | meaning
// S_IDLE   | waiting for start
// S_XFER   | one byte per acked cycle, idx_q selects the byte
// S_FINISH | done pulse for one cycle; a new start is accepted here too
module dmem_access_ctrl #(
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [3:0]  icode_i,
   input  logic [63:0] val_e_i,
   input  logic [63:0] val_a_i,
   input  logic [63:0] val_p_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [63:0] val_m_o,
   output logic        dmem_error_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [63:0] mem_addr_o,
   output logic [7:0]  mem_wdata_o,
   input  logic [7:0]  mem_rdata_i,
   input  logic        mem_ack_i
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_XFER   = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  idx_q;
   logic [63:0] base_q;
   logic [63:0] data_q;
   logic        we_q;
   logic [63:0] asm_q;
   logic [63:0] val_m_q;
   logic        err_q;

   logic        dec_access;
   logic        dec_we;
   logic [63:0] dec_base;
   logic [63:0] dec_data;
   logic [64:0] range_end;
   logic        dec_fault;
   logic        accept;
   logic        xfer;

   // Command decode: direction, base address and write data per icode.
   always_comb begin
      dec_access = 1'b0;
      dec_we     = 1'b0;
      dec_base   = val_e_i;
      dec_data   = val_a_i;
      case (icode_i)
         4'h4: begin dec_access = 1'b1; dec_we = 1'b1; end
         4'h5: begin dec_access = 1'b1; end
         4'h8: begin dec_access = 1'b1; dec_we = 1'b1; dec_data = val_p_i; end
         4'h9: begin dec_access = 1'b1; dec_base = val_a_i; end
         4'hA: begin dec_access = 1'b1; dec_we = 1'b1; end
         4'hB: begin dec_access = 1'b1; dec_base = val_a_i; end
         default: ;
      endcase
   end

   // The 65-bit sum keeps a base near 2^64 from wrapping into a legal range.
   assign range_end = {1'b0, dec_base} + 65'd8;
   assign dec_fault = dec_access && (range_end > 65'(MEM_BYTES));
   assign xfer      = (state_q == S_XFER);
   assign accept    = start_i && !xfer;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_FINISH: begin
            if (start_i) state_d = (dec_access && !dec_fault) ? S_XFER : S_FINISH;
            else         state_d = S_IDLE;
         end
         S_XFER: begin
            if (mem_ack_i && (idx_q == 3'd7)) state_d = S_FINISH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Command latch, byte index, read assembly and valM update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q   <= '0;
         base_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         asm_q   <= '0;
         val_m_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         idx_q  <= '0;
         base_q <= dec_base;
         data_q <= dec_data;
         we_q   <= dec_we;
         err_q  <= dec_fault;
      end else if (xfer && mem_ack_i) begin
         idx_q <= idx_q + 3'd1;
         if (!we_q) begin
            asm_q[{idx_q, 3'b000} +: 8] <= mem_rdata_i;
            // Last byte is merged directly so valM is valid in the FINISH cycle.
            if (idx_q == 3'd7) val_m_q <= {mem_rdata_i, asm_q[55:0]};
         end
      end
   end

   // Request side is zero outside XFER, so reset drops it without waiting for a clock.
   assign busy_o       = xfer;
   assign done_o       = (state_q == S_FINISH);
   assign mem_req_o    = xfer;
   assign mem_we_o     = xfer && we_q;
   assign mem_addr_o   = xfer ? (base_q + {61'd0, idx_q}) : 64'd0;
   assign mem_wdata_o  = xfer ? data_q[{idx_q, 3'b000} +: 8] : 8'd0;
   assign val_m_o      = val_m_q;
   assign dmem_error_o = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: byte-memory responder plus a queue of expected
// (valM, dmem_error) results that is popped whenever done is seen.
module tb_dmem_access_ctrl;

   localparam int MEM_BYTES = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [3:0]  icode_i;
   logic [63:0] val_e_i, val_a_i, val_p_i;
   logic        busy_o, done_o, dmem_error_o;
   logic [63:0] val_m_o;
   logic        mem_req_o, mem_we_o;
   logic [63:0] mem_addr_o;
   logic [7:0]  mem_wdata_o;
   logic [7:0]  mem_rdata_i;
   logic        mem_ack_i;

   dmem_access_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .icode_i      (icode_i),
      .val_e_i      (val_e_i),
      .val_a_i      (val_a_i),
      .val_p_i      (val_p_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .val_m_o      (val_m_o),
      .dmem_error_o (dmem_error_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rdata_i  (mem_rdata_i),
      .mem_ack_i    (mem_ack_i)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] val_m;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  mem [0:MEM_BYTES-1];
   bit          stall_en;
   logic [63:0] model_val_m;
   int          checks;
   int          errors;

   // Responder: decides ack at the falling edge; the byte moves on the next rising edge.
   initial begin
      mem_ack_i   = 1'b0;
      mem_rdata_i = 8'd0;
      forever begin
         @(negedge clk);
         if (mem_req_o === 1'b1) begin
            mem_ack_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (mem_ack_i) begin
               if (mem_we_o) mem[mem_addr_o[9:0]] = mem_wdata_o;
               else          mem_rdata_i = mem[mem_addr_o[9:0]];
            end
         end else begin
            mem_ack_i = 1'b0;
         end
      end
   end

   // Drive one command so it is accepted at the next rising edge.
   task automatic issue(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                        input logic [63:0] p);
      start_i = 1'b1;
      icode_i = ic;
      val_e_i = e;
      val_a_i = a;
      val_p_i = p;
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      start_i = 1'b0;
      icode_i = 4'h0;
      val_e_i = '0;
      val_a_i = '0;
      val_p_i = '0;
      stall_en = 1'b0;
      model_val_m = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy_o, done_o, dmem_error_o, mem_req_o, mem_we_o} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 00000",
                  {busy_o, done_o, dmem_error_o, mem_req_o, mem_we_o});
      end
      checks++;
      if (mem_addr_o !== 64'd0 || mem_wdata_o !== 8'd0) begin
         errors++;
         $display("FAIL reset_addr_wdata: got %h/%h want 0/0", mem_addr_o, mem_wdata_o);
      end
      checks++;
      if (val_m_o !== 64'd0) begin
         errors++;
         $display("FAIL reset_valm: got %h want 0", val_m_o);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_read;
      exp_t ex;
      int   done_cyc;
      for (int i = 0; i < 8; i++) mem[16'h10 + i] = 8'(i + 1);
      stall_en = 1'b0;
      model_val_m = 64'h0807060504030201;
      exp_q.push_back('{val_m: model_val_m, err: 1'b0});
      @(negedge clk);
      #1;
      issue(4'h5, 64'h10, 64'h0, 64'h0);
      done_cyc = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         #1;
         if (done_o) begin done_cyc = c; break; end
         checks++;
         if (mem_addr_o !== 64'h10 + 64'(c - 1) || mem_req_o !== 1'b1 ||
             busy_o !== 1'b1 || mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL read_addr_step: cycle %0d got addr %h req %b busy %b we %b want addr %h req 1 busy 1 we 0",
                     c, mem_addr_o, mem_req_o, busy_o, mem_we_o, 64'h10 + 64'(c - 1));
         end
      end
      checks++;
      if (done_cyc != 9) begin
         errors++;
         $display("FAIL read_done_latency: got %0d want 9", done_cyc);
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL read_scoreboard: got empty queue want one entry");
      end else begin
         ex = exp_q.pop_front();
         if (val_m_o !== ex.val_m || dmem_error_o !== ex.err || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL read_result: got valM %h err %b busy %b want valM %h err %b busy 0",
                     val_m_o, dmem_error_o, busy_o, ex.val_m, ex.err);
         end
      end
   endtask

   task automatic test_write_stall;
      exp_t        ex;
      logic [63:0] wr;
      int          done_cyc;
      int          stalls;
      bit          have_prev;
      logic        prev_ack;
      logic [63:0] prev_addr;
      logic [7:0]  prev_wdata;
      wr = 64'h1122334455667788;
      for (int i = 0; i < 8; i++) mem[16'h40 + i] = 8'h00;
      stall_en = 1'b1;
      exp_q.push_back('{val_m: model_val_m, err: 1'b0});
      @(negedge clk);
      #1;
      issue(4'hA, 64'h40, wr, 64'h0);
      done_cyc = 0;
      stalls = 0;
      have_prev = 1'b0;
      prev_ack = 1'b0;
      prev_addr = '0;
      prev_wdata = '0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         #1;
         if (done_o) begin done_cyc = c; break; end
         checks++;
         if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1) begin
            errors++;
            $display("FAIL write_req_we: cycle %0d got req %b we %b want 1 1", c, mem_req_o, mem_we_o);
         end
         if (have_prev && !prev_ack) begin
            checks++;
            if (mem_addr_o !== prev_addr || mem_wdata_o !== prev_wdata) begin
               errors++;
               $display("FAIL write_stall_stable: cycle %0d got %h/%h want %h/%h",
                        c, mem_addr_o, mem_wdata_o, prev_addr, prev_wdata);
            end
         end
         if (!mem_ack_i) stalls++;
         have_prev = 1'b1;
         prev_ack = mem_ack_i;
         prev_addr = mem_addr_o;
         prev_wdata = mem_wdata_o;
      end
      stall_en = 1'b0;
      checks++;
      if (done_cyc != 9 + stalls) begin
         errors++;
         $display("FAIL write_done_latency: got %0d want %0d", done_cyc, 9 + stalls);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (mem[16'h40 + i] !== wr[8*i +: 8]) begin
            errors++;
            $display("FAIL write_byte_%0d: got %h want %h", i, mem[16'h40 + i], wr[8*i +: 8]);
         end
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL write_scoreboard: got empty queue want one entry");
      end else begin
         ex = exp_q.pop_front();
         if (val_m_o !== ex.val_m || dmem_error_o !== ex.err) begin
            errors++;
            $display("FAIL write_result: got valM %h err %b want valM %h err %b",
                     val_m_o, dmem_error_o, ex.val_m, ex.err);
         end
      end
   endtask

   task automatic test_range;
      logic [3:0]  ic_t  [3];
      logic [63:0] e_t   [3];
      logic [63:0] a_t   [3];
      bit          flt_t [3];
      exp_t        ex;
      int          done_cyc;
      bit          saw_req;
      ic_t = '{4'h8, 4'h9, 4'h5};
      e_t  = '{64'(MEM_BYTES - 7), 64'h0, 64'(MEM_BYTES - 8)};
      a_t  = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
      flt_t = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) mem[MEM_BYTES - 8 + i] = 8'hC0 + 8'(i);
      stall_en = 1'b0;
      for (int t = 0; t < 3; t++) begin
         if (!flt_t[t]) model_val_m = 64'hC7C6C5C4C3C2C1C0;
         exp_q.push_back('{val_m: model_val_m, err: flt_t[t]});
         @(negedge clk);
         #1;
         issue(ic_t[t], e_t[t], a_t[t], 64'h55);
         done_cyc = 0;
         saw_req = 1'b0;
         for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            #1;
            if (mem_req_o) saw_req = 1'b1;
            if (done_o) begin done_cyc = c; break; end
         end
         checks++;
         if (done_cyc != (flt_t[t] ? 1 : 9) || saw_req != !flt_t[t]) begin
            errors++;
            $display("FAIL range_%0d_timing: got done cycle %0d req %b want %0d req %b",
                     t, done_cyc, saw_req, flt_t[t] ? 1 : 9, !flt_t[t]);
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL range_%0d_scoreboard: got empty queue want one entry", t);
         end else begin
            ex = exp_q.pop_front();
            if (val_m_o !== ex.val_m || dmem_error_o !== ex.err) begin
               errors++;
               $display("FAIL range_%0d_result: got valM %h err %b want valM %h err %b",
                        t, val_m_o, dmem_error_o, ex.val_m, ex.err);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      exp_t ex;
      int   done_cyc;
      for (int i = 0; i < 8; i++) mem[i] = 8'h31 + 8'(i);
      stall_en = 1'b0;
      exp_q.push_back('{val_m: model_val_m, err: 1'b0});
      @(negedge clk);
      #1;
      issue(4'h6, 64'h10, 64'h20, 64'h30);
      @(negedge clk);
      #1;
      checks++;
      if (done_o !== 1'b1 || mem_req_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL noacc_finish: got done %b req %b busy %b want 1 0 0", done_o, mem_req_o, busy_o);
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL noacc_scoreboard: got empty queue want one entry");
      end else begin
         ex = exp_q.pop_front();
         if (val_m_o !== ex.val_m || dmem_error_o !== ex.err) begin
            errors++;
            $display("FAIL noacc_result: got valM %h err %b want valM %h err %b",
                     val_m_o, dmem_error_o, ex.val_m, ex.err);
         end
      end
      model_val_m = 64'h3837363534333231;
      exp_q.push_back('{val_m: model_val_m, err: 1'b0});
      issue(4'hB, 64'h0, 64'h0, 64'h0);
      @(negedge clk);
      #1;
      checks++;
      if (busy_o !== 1'b1 || mem_req_o !== 1'b1 || mem_addr_o !== 64'h0 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_idle: got busy %b req %b addr %h done %b want 1 1 0 0",
                  busy_o, mem_req_o, mem_addr_o, done_o);
      end
      done_cyc = 0;
      for (int c = 2; c <= 30; c++) begin
         @(negedge clk);
         #1;
         if (done_o) begin done_cyc = c; break; end
      end
      checks++;
      if (done_cyc != 9) begin
         errors++;
         $display("FAIL b2b_done_latency: got %0d want 9", done_cyc);
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL b2b_scoreboard: got empty queue want one entry");
      end else begin
         ex = exp_q.pop_front();
         if (val_m_o !== ex.val_m || dmem_error_o !== ex.err) begin
            errors++;
            $display("FAIL b2b_result: got valM %h err %b want valM %h err %b",
                     val_m_o, dmem_error_o, ex.val_m, ex.err);
         end
      end
   endtask

   task automatic test_reset_mid;
      exp_t ex;
      int   done_cyc;
      for (int i = 0; i < 8; i++) mem[16'h80 + i] = 8'h50 + 8'(i);
      stall_en = 1'b0;
      @(negedge clk);
      #1;
      issue(4'h4, 64'h80, 64'hA1A2A3A4A5A6A7A8, 64'h0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({busy_o, done_o, dmem_error_o, mem_req_o, mem_we_o} !== 5'b0 ||
          mem_addr_o !== 64'd0 || mem_wdata_o !== 8'd0 || val_m_o !== 64'd0) begin
         errors++;
         $display("FAIL midrst_outputs: got flags %b addr %h wdata %h valM %h want all 0",
                  {busy_o, done_o, dmem_error_o, mem_req_o, mem_we_o}, mem_addr_o, mem_wdata_o, val_m_o);
      end
      model_val_m = '0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      model_val_m = 64'h5756555453A6A7A8;
      exp_q.push_back('{val_m: model_val_m, err: 1'b0});
      issue(4'h5, 64'h80, 64'h0, 64'h0);
      done_cyc = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         #1;
         if (done_o) begin done_cyc = c; break; end
      end
      checks++;
      if (done_cyc != 9) begin
         errors++;
         $display("FAIL midrst_read_latency: got %0d want 9", done_cyc);
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL midrst_scoreboard: got empty queue want one entry");
      end else begin
         ex = exp_q.pop_front();
         if (val_m_o !== ex.val_m || dmem_error_o !== ex.err) begin
            errors++;
            $display("FAIL midrst_read_result: got valM %h err %b want valM %h err %b",
                     val_m_o, dmem_error_o, ex.val_m, ex.err);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
      test_reset();
      test_read();
      test_write_stall();
      test_range();
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation time limit want completion");
      $fatal(1, "time limit reached");
   end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Multi-cycle data-memory access initiator for the sequential Y86 core. It takes the memory-stage command (icode, valE, valA, valP) and decides read or write, address and write data. It then moves the 64-bit word over a byte-wide req/ack port to the data-memory responder, little-endian, and returns valM with a done pulse. Out-of-range addresses are flagged without touching memory.

## Interface
- MEM_BYTES, 1024: size of data memory in bytes; a legal access needs addr + 7 <= MEM_BYTES - 1.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  command valid; accepted only when state is IDLE or FINISH.
- icode  input  4  instruction code of the command.
- valE, valA, valP  input  64 each  stage operands, latched on accept.
- busy  output  1  high while in XFER.
- done  output  1  one-cycle pulse in FINISH.
- valM  output  64  assembled read word; holds its value until the next read completes.
- dmem_error  output  1  address-range fault; valid in FINISH, held until the next accept.
- mem_req  output  1  byte request to the data memory.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  output  64  byte address.
- mem_wdata  output  8  write byte.
- mem_rdata  input  8  read byte; sampled on the edge where mem_ack = 1.
- mem_ack  input  1  responder completes the current byte; ignored while mem_req = 0.

## Operation
- Decode at accept (op, base, data):
  - 4'h4 rmmovq: write, base valE, data valA.
  - 4'h5 mrmovq: read, base valE.
  - 4'h8 call: write, base valE, data valP.
  - 4'h9 ret: read, base valA.
  - 4'hA pushq: write, base valE, data valA.
  - 4'hB popq: read, base valA.
  - Any other icode: no access.
- Range check: compute {1'b0, base} + 8 in 65 bits; fault if the result > MEM_BYTES. This catches wrap-around near 2^64.
- States:
  - IDLE: waits for start.
  - XFER: transfers bytes.
  - FINISH: pulses done, lasts one cycle.
- Transitions:
  - IDLE/FINISH + start, legal access -> XFER with idx = 0.
  - IDLE/FINISH + start, fault or no-access icode -> FINISH. No mem_req is issued. dmem_error = fault.
  - FINISH without start -> IDLE.
  - XFER + mem_ack, idx < 7 -> XFER with idx + 1.
  - XFER + mem_ack, idx = 7 -> FINISH.
  - XFER without mem_ack -> hold; mem_req, mem_addr, mem_we and mem_wdata stay stable.
- In XFER:
  - mem_req = 1.
  - mem_addr = base + idx.
  - mem_wdata = data[8*idx+7 : 8*idx].
  - On each acked read byte, mem_rdata is stored into byte idx of a 64-bit assembly register.
- On the transition into FINISH for a read, valM is loaded from the assembly register with byte 7 merged in. Writes and no-access commands leave valM unchanged.
- start while in XFER is ignored and is not queued.
- Reset values: state IDLE; busy, done, dmem_error, mem_req and mem_we = 0; mem_addr and valM = 0; mem_wdata = 0.
- Reset mid-transfer: mem_req drops immediately (asynchronously). Bytes already written stay in memory; partial writes are not rolled back.

## Timing
- Accept at edge N. Then:
  - busy and mem_req are high from cycle N+1.
  - With mem_ack held high, byte k is in flight in cycle N+1+k.
  - done is high in cycle N+9.
  - valM is valid from cycle N+9.
- Each extra cycle with mem_ack = 0 adds one cycle of latency.
- Fault or no-access command: done in cycle N+1, with no request issued.
- Back-to-back operation: start asserted during the FINISH cycle is accepted, so there are no idle cycles between commands.
- busy = 0 and done = 1 in the FINISH cycle.
- dmem_error changes only on accept.

## Test plan
- Read, ack tied high:
  - Stimulus: preload bytes 0x10..0x17 with 0x01..0x08, then mrmovq with valE = 0x10.
  - Required: mem_addr steps 0x10..0x17 over 8 cycles; done at N+9; valM = 0x0807060504030201; dmem_error = 0.
- Write with random ack stalls:
  - Stimulus: pushq with valE = 0x40, valA = 0x1122334455667788.
  - Required: bytes 0x88, 0x77, …, 0x11 appear at 0x40..0x47; mem_addr, mem_we and mem_wdata stay stable through stalls; valM unchanged.
- Range faults:
  - Stimulus: call with valE = MEM_BYTES - 7, then ret with valA = 0xFFFF_FFFF_FFFF_FFFC.
  - Required: no mem_req; done at N+1 with dmem_error = 1 for both commands.
- No-access command followed by back-to-back access:
  - Stimulus: icode 4'h6, then start asserted in its FINISH cycle with popq at valA = 0.
  - Required: done at N+1 with no request; popq accepted without an idle cycle and completes normally.
- Reset mid-operation:
  - Stimulus: assert rst after 3 bytes of a write.
  - Required: mem_req and all outputs go to 0 immediately; state returns to IDLE; a new read after reset returns the 3 new bytes plus the old bytes.
